// File: rtl/jk_excite_driver.sv
// Excitation driver for an external negedge JK register bank: walks the bank to a
// requested word a few bits per clock, keeps a shadow copy and verifies by readback.
module jk_excite_driver #(
    parameter int W          = 8,
    parameter int MAX_FLIPS  = 2,
    parameter bit USE_TOGGLE = 1'b1
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic [W-1:0] TGT,
    input  logic         TGT_VALID,
    output logic         TGT_READY,
    output logic [W-1:0] J,
    output logic [W-1:0] K,
    input  logic [W-1:0] QFB,
    output logic         BUSY,
    output logic         DONE,
    output logic         ERR
);

    typedef enum logic [2:0] {
        S_INIT,
        S_INIT_CLR,
        S_IDLE,
        S_DRIVE,
        S_CHECK
    } state_t;

    state_t       state, state_nxt;
    logic [W-1:0] shadow, shadow_nxt;
    logic [W-1:0] target, target_nxt;
    logic [W-1:0] j_nxt, k_nxt;
    logic         done_nxt, err_nxt;
    logic [W-1:0] goal, diff, sel, j_drv, k_drv;
    logic         accept;

    // Lowest-index set bits of d, at most MAX_FLIPS of them.
    function automatic logic [W-1:0] pick_low(input logic [W-1:0] d);
        logic [W-1:0] s;
        int           n;
        s = '0;
        n = 0;
        for (int i = 0; i < W; i++) begin
            if (d[i] && (n < MAX_FLIPS)) begin
                s[i] = 1'b1;
                n++;
            end
        end
        return s;
    endfunction

    // In IDLE the first slice is issued on the accept edge, so use the live input.
    assign goal   = (state == S_IDLE) ? TGT : target;
    assign diff   = shadow ^ goal;
    assign sel    = pick_low(diff);
    assign j_drv  = USE_TOGGLE ? sel : (sel & goal);
    assign k_drv  = USE_TOGGLE ? sel : (sel & ~goal);
    // Ready is held off during the DONE cycle so a new target starts one cycle later.
    assign accept = (state == S_IDLE) && TGT_VALID && !DONE;

    assign TGT_READY = (state == S_IDLE) && !DONE;
    assign BUSY      = (state != S_IDLE);

    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        target_nxt = target;
        j_nxt      = '0;
        k_nxt      = '0;
        done_nxt   = 1'b0;
        err_nxt    = ERR;
        case (state)
            S_INIT: begin
                k_nxt     = '1;
                state_nxt = S_INIT_CLR;
            end
            S_INIT_CLR: state_nxt = S_IDLE;
            S_IDLE: begin
                if (accept) begin
                    target_nxt = TGT;
                    err_nxt    = 1'b0;
                    if (diff == '0) begin
                        state_nxt = S_CHECK;
                    end else begin
                        j_nxt      = j_drv;
                        k_nxt      = k_drv;
                        shadow_nxt = shadow ^ sel;
                        state_nxt  = S_DRIVE;
                    end
                end
            end
            S_DRIVE: begin
                if (diff == '0) begin
                    state_nxt = S_CHECK;
                end else begin
                    j_nxt      = j_drv;
                    k_nxt      = k_drv;
                    shadow_nxt = shadow ^ sel;
                end
            end
            S_CHECK: begin
                if (QFB != shadow) err_nxt = 1'b1;
                done_nxt  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state  <= S_INIT;
            shadow <= '0;
            target <= '0;
            J      <= '0;
            K      <= '0;
            DONE   <= 1'b0;
            ERR    <= 1'b0;
        end else begin
            state  <= state_nxt;
            shadow <= shadow_nxt;
            target <= target_nxt;
            J      <= j_nxt;
            K      <= k_nxt;
            DONE   <= done_nxt;
            ERR    <= err_nxt;
        end
    end

endmodule

// File: tb/tb_jk_excite_driver.sv
// Bench for jk_excite_driver: toggle-mode and set/reset-mode instances run in lockstep,
// each driving its own negedge JK bank model; outputs are compared against a vector table.
module tb_jk_excite_driver;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] tgt;
    logic       tgt_valid;
    logic       fault;

    logic       rdy_t, bsy_t, dn_t, er_t;
    logic       rdy_s, bsy_s, dn_s, er_s;
    logic [7:0] j_t, k_t, j_s, k_s;
    logic [7:0] bq_t = 8'hA5;
    logic [7:0] bq_s = 8'hA5;
    logic [7:0] qfb_t, qfb_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // External JK banks, negedge sampled; fault models bit 0 of the readback stuck at 0.
    always @(negedge clk) begin
        bq_t <= (j_t & ~bq_t) | (~k_t & bq_t);
        bq_s <= (j_s & ~bq_s) | (~k_s & bq_s);
    end
    assign qfb_t = bq_t & ~{7'b0, fault};
    assign qfb_s = bq_s & ~{7'b0, fault};

    jk_excite_driver #(.W(8), .MAX_FLIPS(2), .USE_TOGGLE(1'b1)) u_tog (
        .CLK(clk), .CLR(clr), .TGT(tgt), .TGT_VALID(tgt_valid), .TGT_READY(rdy_t),
        .J(j_t), .K(k_t), .QFB(qfb_t), .BUSY(bsy_t), .DONE(dn_t), .ERR(er_t)
    );

    jk_excite_driver #(.W(8), .MAX_FLIPS(2), .USE_TOGGLE(1'b0)) u_sr (
        .CLK(clk), .CLR(clr), .TGT(tgt), .TGT_VALID(tgt_valid), .TGT_READY(rdy_s),
        .J(j_s), .K(k_s), .QFB(qfb_s), .BUSY(bsy_s), .DONE(dn_s), .ERR(er_s)
    );

    typedef struct {
        logic       v;
        logic [7:0] tgt;
        logic       flt;
        logic       rdy, bsy, dn, er;
        logic [7:0] jt, kt, js, ks, q;
    } vec_t;

    vec_t tbl[24];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic check_vec(input string tag, input vec_t e);
        chk({tag, " rdy_t"}, {7'b0, rdy_t}, {7'b0, e.rdy});
        chk({tag, " rdy_s"}, {7'b0, rdy_s}, {7'b0, e.rdy});
        chk({tag, " bsy_t"}, {7'b0, bsy_t}, {7'b0, e.bsy});
        chk({tag, " bsy_s"}, {7'b0, bsy_s}, {7'b0, e.bsy});
        chk({tag, " done_t"}, {7'b0, dn_t}, {7'b0, e.dn});
        chk({tag, " done_s"}, {7'b0, dn_s}, {7'b0, e.dn});
        chk({tag, " err_t"}, {7'b0, er_t}, {7'b0, e.er});
        chk({tag, " err_s"}, {7'b0, er_s}, {7'b0, e.er});
        chk({tag, " j_t"}, j_t, e.jt);
        chk({tag, " k_t"}, k_t, e.kt);
        chk({tag, " j_s"}, j_s, e.js);
        chk({tag, " k_s"}, k_s, e.ks);
        chk({tag, " q_t"}, qfb_t, e.q);
        chk({tag, " q_s"}, qfb_s, e.q);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            v  tgt   flt rdy bsy dn er  jt     kt     js     ks     q
        tbl[0]  = '{0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hA5};
        tbl[1]  = '{0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[2]  = '{1, 8'h0F, 0, 0, 1, 0, 0, 8'h03, 8'h03, 8'h03, 8'h00, 8'h00};
        tbl[3]  = '{0, 8'h00, 0, 0, 1, 0, 0, 8'h0C, 8'h0C, 8'h0C, 8'h00, 8'h03};
        tbl[4]  = '{0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F};
        tbl[5]  = '{0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F};
        tbl[6]  = '{0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F};
        tbl[7]  = '{1, 8'hF0, 0, 0, 1, 0, 0, 8'h03, 8'h03, 8'h00, 8'h03, 8'h0F};
        tbl[8]  = '{0, 8'h00, 0, 0, 1, 0, 0, 8'h0C, 8'h0C, 8'h00, 8'h0C, 8'h0C};
        tbl[9]  = '{0, 8'h00, 0, 0, 1, 0, 0, 8'h30, 8'h30, 8'h30, 8'h00, 8'h00};
        tbl[10] = '{0, 8'h00, 0, 0, 1, 0, 0, 8'hC0, 8'hC0, 8'hC0, 8'h00, 8'h30};
        tbl[11] = '{0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0};
        tbl[12] = '{0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0};
        tbl[13] = '{0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0};
        tbl[14] = '{1, 8'hF0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0};
        tbl[15] = '{0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0};
        tbl[16] = '{0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0};
        tbl[17] = '{1, 8'h01, 1, 0, 1, 0, 0, 8'h11, 8'h11, 8'h01, 8'h10, 8'hF0};
        tbl[18] = '{0, 8'h00, 1, 0, 1, 0, 0, 8'h60, 8'h60, 8'h00, 8'h60, 8'hE0};
        tbl[19] = '{0, 8'h00, 1, 0, 1, 0, 0, 8'h80, 8'h80, 8'h00, 8'h80, 8'h80};
        tbl[20] = '{0, 8'h00, 1, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[21] = '{0, 8'h00, 1, 0, 0, 1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[22] = '{0, 8'h00, 1, 1, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[23] = '{0, 8'h00, 1, 1, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        clr       = 1'b0;
        tgt       = 8'h00;
        tgt_valid = 1'b0;
        fault     = 1'b0;
        tick;
        tick;
        check_vec("reset", '{0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5});
        clr = 1'b1;

        for (int i = 0; i < 24; i++) begin
            tgt       = tbl[i].tgt;
            tgt_valid = tbl[i].v;
            fault     = tbl[i].flt;
            tick;
            check_vec($sformatf("r%0d", i), tbl[i]);
        end

        // Abort target 0xFF from 0x01 during its second DRIVE cycle.
        fault     = 1'b0;
        tgt       = 8'hFF;
        tgt_valid = 1'b1;
        tick;
        check_vec("abort d1", '{0, 8'h00, 0, 0, 1, 0, 0, 8'h06, 8'h06, 8'h06, 8'h00, 8'h01});
        tgt_valid = 1'b0;
        tick;
        check_vec("abort d2", '{0, 8'h00, 0, 0, 1, 0, 0, 8'h18, 8'h18, 8'h18, 8'h00, 8'h07});
        clr = 1'b0;
        #1;
        check_vec("abort clr", '{0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07});
        for (int i = 0; i < 2; i++) begin
            tick;
            check_vec($sformatf("abort hold%0d", i),
                      '{0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07});
        end
        clr = 1'b1;
        tick;
        check_vec("reinit clr", '{0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h07});
        tick;
        check_vec("reinit idle", '{0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        for (int i = 0; i < 3; i++) begin
            tick;
            check_vec($sformatf("post idle%0d", i),
                      '{0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
